fnd_scan_ctrl: RTL

//  Drives a 4-digit common-anode 7-segment display (FND) from a 12-bit binary value.
//  On a load request it converts the value to BCD by sequential double-dabble, one bit
//  per clock, and the display keeps showing the previous value until conversion completes.
//  It then time-multiplexes the four digits through the 7-seg decode and one-hot digit select.
//  It sits between datapath results (adder/comparator outputs) and the board FND pins.

---
 rtl/fnd_scan_ctrl_pkg.sv | 40 ++++
 rtl/fnd_scan_ctrl_if.sv | 13 +
 rtl/fnd_scan_ctrl_bin_to_dec_seq.sv | 62 ++++++
 rtl/fnd_scan_ctrl.sv | 72 +++++++
 4 files changed

// File: rtl/fnd_scan_ctrl_pkg.sv
// rtl/fnd_scan_ctrl_pkg.sv - shared constants, FSM encodings and helpers for the FND scan controller
package fnd_scan_ctrl_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int         DD_STEPS  = 12;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Active-low abcd_efgp pattern for one BCD digit; anything above 9 is blanked.
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'b0000_0011;
      4'd1:    s = 8'b1001_1111;
      4'd2:    s = 8'b0010_0101;
      4'd3:    s = 8'b0000_1101;
      4'd4:    s = 8'b1001_1001;
      4'd5:    s = 8'b0100_1001;
      4'd6:    s = 8'b0100_0001;
      4'd7:    s = 8'b0001_1011;
      4'd8:    s = 8'b0000_0001;
      4'd9:    s = 8'b0000_1001;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every nibble above 4 gets +3 before the next shift.
  function automatic logic [15:0] dd_adjust(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[i*4 +: 4] > 4'd4) r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/fnd_scan_ctrl_if.sv
// rtl/fnd_scan_ctrl_if.sv - value/load handshake and display pins of the FND scan controller
interface fnd_scan_ctrl_if;
  logic [11:0] value;
  logic        load;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic [3:0]  com;
  logic [7:0]  seg_7;

  modport master (output value, load, input busy, done, bcd, com, seg_7);
  modport slave  (input value, load, output busy, done, bcd, com, seg_7);
endinterface

// File: rtl/fnd_scan_ctrl_bin_to_dec_seq.sv
// rtl/fnd_scan_ctrl_bin_to_dec_seq.sv - sequential 12-bit binary to BCD converter, one bit per clock
module bin_to_dec_seq
  import fnd_scan_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [11:0] value,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd
);

  logic [1:0]  state;
  logic [11:0] shift;
  logic [15:0] scratch;
  logic [3:0]  step;
  logic [15:0] adj;
  logic [15:0] next_scratch;

  // Shift the corrected scratch left and bring in the next value MSB.
  assign adj          = dd_adjust(scratch);
  assign next_scratch = (adj << 1) | {15'd0, shift[11]};

  assign busy = (state == CONV);
  assign done = (state == DONE);

  // Conversion FSM; bcd is only written on the last step so the display keeps the old value.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      shift   <= '0;
      scratch <= '0;
      step    <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (load) begin
            shift   <= value;
            scratch <= '0;
            step    <= '0;
            state   <= CONV;
          end else begin
            state   <= IDLE;
          end
        end
        CONV: begin
          scratch <= next_scratch;
          shift   <= {shift[10:0], 1'b0};
          step    <= step + 4'd1;
          if (step == 4'(DD_STEPS - 1)) begin
            bcd   <= next_scratch;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// rtl/fnd_scan_ctrl.sv - 4-digit common-anode FND driver: BCD conversion plus digit scan
module fnd_scan_ctrl
  import fnd_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 100_000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  fnd_scan_ctrl_if.slave bus
);

  localparam int             DW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] divider;
  logic [1:0]    idx;
  logic [15:0]   bcd;
  logic          z3, z2, z1;
  logic [3:0]    blank;
  logic [3:0]    nib;
  logic [7:0]    seg_next;

  bin_to_dec_seq u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (bus.load),
    .value   (bus.value),
    .busy    (bus.busy),
    .done    (bus.done),
    .bcd     (bcd)
  );

  assign bus.bcd = bcd;

  // A digit above the ones is blank when it and every more significant digit are zero.
  assign z3    = (bcd[15:12] == 4'd0);
  assign z2    = z3 && (bcd[11:8] == 4'd0);
  assign z1    = z2 && (bcd[7:4] == 4'd0);
  assign blank = BLANK_LZ ? {z3, z2, z1, 1'b0} : 4'b0000;

  // Pick the nibble for the current slot and decode it, or blank it.
  always_comb begin
    nib      = bcd[{idx, 2'b00} +: 4];
    seg_next = blank[idx] ? SEG_BLANK : seg_of(nib);
  end

  // Slot timer: free-running divider advances the digit index on each wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      divider <= '0;
      idx     <= 2'd0;
    end else if (divider == DIV_LAST) begin
      divider <= '0;
      idx     <= idx + 2'd1;
    end else begin
      divider <= divider + 1'b1;
    end
  end

  // Registered pin drive so com and seg_7 change together, one cycle behind idx.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.com   <= 4'b1110;
      bus.seg_7 <= 8'b0000_0011;
    end else begin
      bus.com   <= ~(4'b0001 << idx);
      bus.seg_7 <= seg_next;
    end
  end

endmodule
